// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Self-running exhaustive tester for a WIDTH-input, single-output combinational
//   gate. Steps pattern_out through 0..2^WIDTH-1 in ascending order, holding each
//   pattern for HOLD clocks, and samples dut_resp on the last clock of each hold.
//   The sample is compared with a reduction function (NOR/OR/AND/NAND) of the
//   pattern. Mismatch count, lowest failing pattern and pass/fail are published
//   when a sweep completes.
//
// Parameters
//   WIDTH  number of DUT inputs (>=1)
//   HOLD   clocks each pattern is held (>=1)
//   MODE   0 = one-shot sweep, 1 = continuous re-sweep until abort
//   FUNC   expected function: 0 NOR, 1 OR, 2 AND, 3 NAND (reduction)
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   start, abort       begin sweep (IDLE/DONE only) / return to IDLE (wins over start)
//   dut_resp           DUT output for the current pattern_out
//   pattern_out        DUT input pattern
//   busy, done         sweeping / sweep complete (level in MODE 0, pulse in MODE 1)
//   pass, err_valid    last sweep had zero / non-zero mismatches
//   err_count          mismatches in last completed sweep (0..2^WIDTH)
//   first_err_pattern  lowest failing pattern of last completed sweep
module gate_sweep_checker #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 50,
    parameter int MODE  = 0,
    parameter int FUNC  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_resp,
    output logic [WIDTH-1:0] pattern_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] first_err_pattern,
    output logic             err_valid
);

    localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [WIDTH:0]   run_cnt_q, run_cnt_d;
    logic             run_flag_q, run_flag_d;
    logic [WIDTH-1:0] run_first_q, run_first_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [WIDTH:0]   err_count_q, err_count_d;
    logic [WIDTH-1:0] first_err_q, first_err_d;
    logic             err_valid_q, err_valid_d;

    logic             exp_bit;
    logic             sample;
    logic             mismatch;
    logic             first_hit;
    logic [WIDTH:0]   cnt_next;

    always_comb begin
        case (FUNC)
            1:       exp_bit = |pattern_q;
            2:       exp_bit = &pattern_q;
            3:       exp_bit = ~&pattern_q;
            default: exp_bit = ~|pattern_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        hold_d      = hold_q;
        run_cnt_d   = run_cnt_q;
        run_flag_d  = run_flag_q;
        run_first_d = run_first_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        err_valid_d = err_valid_q;

        sample    = (state_q == DRIVE) && (hold_q == HC_W'(HOLD - 1));
        mismatch  = sample && (dut_resp != exp_bit);
        first_hit = mismatch && !run_flag_q;
        // Running count cannot overflow: at most 2^WIDTH samples per sweep.
        cnt_next  = run_cnt_q + {{WIDTH{1'b0}}, mismatch};

        if (abort) begin
            state_d     = IDLE;
            pattern_d   = '0;
            hold_d      = '0;
            run_cnt_d   = '0;
            run_flag_d  = 1'b0;
            run_first_d = '0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d     = DRIVE;
                        pattern_d   = '0;
                        hold_d      = '0;
                        run_cnt_d   = '0;
                        run_flag_d  = 1'b0;
                        run_first_d = '0;
                        busy_d      = 1'b1;
                        done_d      = 1'b0;
                    end
                end
                DRIVE: begin
                    if (MODE == 1) begin
                        done_d = 1'b0;
                    end
                    if (sample) begin
                        hold_d    = '0;
                        run_cnt_d = cnt_next;
                        if (first_hit) begin
                            run_flag_d  = 1'b1;
                            run_first_d = pattern_q;
                        end
                        if (pattern_q == '1) begin
                            // Publish using this cycle's sample folded in, then
                            // start the running state afresh for any next sweep.
                            err_count_d = cnt_next;
                            first_err_d = first_hit ? pattern_q : run_first_q;
                            err_valid_d = (cnt_next != '0);
                            pass_d      = (cnt_next == '0);
                            pattern_d   = '0;
                            run_cnt_d   = '0;
                            run_flag_d  = 1'b0;
                            run_first_d = '0;
                            done_d      = 1'b1;
                            if (MODE == 0) begin
                                state_d = DONE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            pattern_d = pattern_q + WIDTH'(1);
                        end
                    end else begin
                        hold_d = hold_q + HC_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            hold_q      <= '0;
            run_cnt_q   <= '0;
            run_flag_q  <= 1'b0;
            run_first_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            first_err_q <= '0;
            err_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            hold_q      <= hold_d;
            run_cnt_q   <= run_cnt_d;
            run_flag_q  <= run_flag_d;
            run_first_q <= run_first_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign pattern_out       = pattern_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign pass              = pass_q;
    assign err_count         = err_count_q;
    assign first_err_pattern = first_err_q;
    assign err_valid         = err_valid_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
module tb_gate_sweep_checker;

    typedef struct packed {
        logic [4:0] cnt;
        logic [3:0] first;
        logic       pass;
        logic       valid;
    } res_t;

    logic clk;
    logic rst;

    // dut0: one-shot, NOR.  dut1: continuous, AND.
    logic       start0, abort0, resp0;
    logic [3:0] pat0;
    logic       busy0, done0, pass0, ev0;
    logic [4:0] ec0;
    logic [3:0] fe0;

    logic       start1, abort1, resp1;
    logic [3:0] pat1;
    logic       busy1, done1, pass1, ev1;
    logic [4:0] ec1;
    logic [3:0] fe1;

    int rmode0;   // 0 ideal NOR, 1 stuck-at-0, 2 stuck-at-1
    int rmode1;   // 0 ideal AND, 1 stuck-at-0

    int checks;
    int failures;

    res_t q0[$];
    res_t q1[$];
    res_t e0, e1;
    logic done0_prev;

    assign resp0 = (rmode0 == 0) ? ~|pat0 : (rmode0 == 1) ? 1'b0 : 1'b1;
    assign resp1 = (rmode1 == 0) ? &pat1 : 1'b0;

    gate_sweep_checker #(.WIDTH(4), .HOLD(4), .MODE(0), .FUNC(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .dut_resp(resp0),
        .pattern_out(pat0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(ec0), .first_err_pattern(fe0), .err_valid(ev0)
    );

    gate_sweep_checker #(.WIDTH(4), .HOLD(4), .MODE(1), .FUNC(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .dut_resp(resp1),
        .pattern_out(pat1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(ec1), .first_err_pattern(fe1), .err_valid(ev1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t mk(input int cnt, input int first, input int p, input int v);
        res_t r;
        r.cnt   = 5'(cnt);
        r.first = 4'(first);
        r.pass  = 1'(p);
        r.valid = 1'(v);
        return r;
    endfunction

    // Scoreboard monitors: pop and compare whenever a sweep result is presented.
    always @(negedge clk) begin
        if (done0 && !done0_prev) begin
            if (q0.size() == 0) begin
                chk("sb0_unexpected_done", 1, 0);
            end else begin
                e0 = q0.pop_front();
                chk("sb0_err_count", int'(ec0), int'(e0.cnt));
                chk("sb0_first_err", int'(fe0), int'(e0.first));
                chk("sb0_pass", int'(pass0), int'(e0.pass));
                chk("sb0_err_valid", int'(ev0), int'(e0.valid));
            end
        end
        done0_prev = done0;
    end

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                chk("sb1_unexpected_done", 1, 0);
            end else begin
                e1 = q1.pop_front();
                chk("sb1_err_count", int'(ec1), int'(e1.cnt));
                chk("sb1_first_err", int'(fe1), int'(e1.first));
                chk("sb1_pass", int'(pass1), int'(e1.pass));
                chk("sb1_err_valid", int'(ev1), int'(e1.valid));
            end
        end
    end

    task automatic all_zero0(input string tag);
        chk({tag, "_pat"}, int'(pat0), 0);
        chk({tag, "_busy"}, int'(busy0), 0);
        chk({tag, "_done"}, int'(done0), 0);
        chk({tag, "_pass"}, int'(pass0), 0);
        chk({tag, "_ec"}, int'(ec0), 0);
        chk({tag, "_fe"}, int'(fe0), 0);
        chk({tag, "_ev"}, int'(ev0), 0);
    endtask

    // Full one-shot sweep on dut0 with pattern stepping and latency checks.
    task automatic sweep0(input string tag);
        int c;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk({tag, "_busy_start"}, int'(busy0), 1);
        chk({tag, "_done_clr"}, int'(done0), 0);
        c = 0;
        while (!done0 && c < 200) begin
            if (c < 64) chk({tag, "_pattern"}, int'(pat0), c / 4);
            tick();
            c++;
        end
        chk({tag, "_latency"}, c, 64);
        chk({tag, "_busy_end"}, int'(busy0), 0);
        chk({tag, "_pat_end"}, int'(pat0), 0);
        tick();
        chk({tag, "_done_level"}, int'(done0), 1);
    endtask

    initial begin
        int c;
        logic [3:0] prev_pat;
        checks = 0;
        failures = 0;
        done0_prev = 1'b0;
        rst = 1'b1;
        start0 = 0; abort0 = 0; start1 = 0; abort1 = 0;
        rmode0 = 0; rmode1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        all_zero0("reset0");
        chk("reset1_busy", int'(busy1), 0);
        chk("reset1_done", int'(done1), 0);

        // T1 ideal
        rmode0 = 0;
        q0.push_back(mk(0, 0, 1, 0));
        sweep0("t1");
        // T3 stuck-at-1: patterns 1..15 fail
        rmode0 = 2;
        q0.push_back(mk(15, 1, 0, 1));
        sweep0("t3");
        // T2 stuck-at-0: only pattern 0 fails
        rmode0 = 1;
        q0.push_back(mk(1, 0, 0, 1));
        sweep0("t2");

        // T4 abort mid-sweep, results of T2 retained
        rmode0 = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (20) tick();
        chk("t4_busy_mid", int'(busy0), 1);
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        chk("t4_busy_abort", int'(busy0), 0);
        chk("t4_pat_abort", int'(pat0), 0);
        chk("t4_done_abort", int'(done0), 0);
        chk("t4_ec_kept", int'(ec0), 1);
        chk("t4_fe_kept", int'(fe0), 0);
        chk("t4_pass_kept", int'(pass0), 0);
        chk("t4_ev_kept", int'(ev0), 1);
        repeat (3) tick();
        chk("t4_idle_hold", int'(busy0), 0);
        q0.push_back(mk(0, 0, 1, 0));
        sweep0("t4");

        // T5 continuous AND: two ideal sweeps then two with stuck-at-0 (fails only 15)
        rmode1 = 0;
        q1.push_back(mk(0, 0, 1, 0));
        q1.push_back(mk(0, 0, 1, 0));
        q1.push_back(mk(1, 15, 0, 1));
        q1.push_back(mk(1, 15, 0, 1));
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int s = 0; s < 4; s++) begin
            c = (s == 0) ? 0 : 1;
            prev_pat = pat1;
            while (!done1 && c < 200) begin
                prev_pat = pat1;
                if (s == 1 && c == 30) start1 = 1'b1;
                tick();
                start1 = 1'b0;
                c++;
            end
            chk("t5_period", c, 64);
            chk("t5_prev_pat", int'(prev_pat), 15);
            chk("t5_wrap_pat", int'(pat1), 0);
            chk("t5_busy", int'(busy1), 1);
            if (s == 1) rmode1 = 1;
            tick();
            chk("t5_pulse_width", int'(done1), 0);
        end
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        chk("t5_busy_abort", int'(busy1), 0);
        chk("t5_pat_abort", int'(pat1), 0);
        chk("t5_ec_kept", int'(ec1), 1);
        chk("t5_fe_kept", int'(fe1), 15);

        // T6 async reset between edges, then start+abort together
        rmode0 = 1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (10) tick();
        chk("t6_busy_pre", int'(busy0), 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        all_zero0("t6_rst");
        chk("t6_rst1_ec", int'(ec1), 0);
        chk("t6_rst1_fe", int'(fe1), 0);
        #1 rst = 1'b0;
        start0 = 1'b1;
        abort0 = 1'b1;
        tick();
        start0 = 1'b0;
        abort0 = 1'b0;
        chk("t6_sa_busy", int'(busy0), 0);
        chk("t6_sa_pat", int'(pat0), 0);
        repeat (5) tick();
        all_zero0("t6_idle");

        tick();
        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
